alu_issue_stage: RTL and testbench

Sequencing stage that sits directly upstream of alu_4bit and also takes back its result. It accepts one instruction at a time over a valid/ready handshake and reads two operands from a 4-entry x 4-bit register file. It drives operand1, operand2 and ALUctrl to the ALU, then writes the ALU result back and updates the zero and carry flags. This turns the combinational ALU into a usable, sequenced execution unit.

---
 rtl/alu_issue_stage_pkg.sv | 52 +++++
 rtl/alu_issue_stage_regfile_4x4.sv | 38 +++
 rtl/alu_issue_stage.sv | 143 ++++++++++++++
 tb/tb_alu_issue_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU issue stage.
// Holds datapath widths, opcode encodings, FSM state encoding, instruction
// field bit positions and small opcode-classification helpers used by both
// the stage controller and its register file.
package alu_issue_stage_pkg;

  localparam int DATA_W  = 4;
  localparam int REG_CNT = 4;
  localparam int REG_AW  = 2;
  localparam int INSTR_W = 16;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_NOT = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0101;
  localparam logic [3:0] OP_LDI = 4'b1000;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 10;
  localparam int RS1_HI = 9;
  localparam int RS1_LO = 8;
  localparam int RS2_HI = 7;
  localparam int RS2_LO = 6;
  localparam int IMM_HI = 3;
  localparam int IMM_LO = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  // Opcodes that are executed by the external ALU.
  function automatic logic is_alu_op(input logic [3:0] opcode);
    return (opcode == OP_AND) || (opcode == OP_OR)  || (opcode == OP_NOT) ||
           (opcode == OP_XOR) || (opcode == OP_ADD) || (opcode == OP_SUB);
  endfunction

  // Only ADD and SUB produce a meaningful carry.
  function automatic logic is_arith_op(input logic [3:0] opcode);
    return (opcode == OP_ADD) || (opcode == OP_SUB);
  endfunction

  function automatic logic is_legal_op(input logic [3:0] opcode);
    return is_alu_op(opcode) || (opcode == OP_LDI);
  endfunction

endpackage

// File: rtl/alu_issue_stage_regfile_4x4.sv
// 4-entry x 4-bit register file for the ALU issue stage.
// Ports: clk, rst (sync, active-high, clears all entries); we/waddr/wdata
// synchronous write port; raddr1/rdata1 and raddr2/rdata2 combinational read
// ports; dbg_sel/dbg_data combinational debug read port.
module regfile_4x4
  import alu_issue_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic [REG_AW-1:0] dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [REG_CNT];

  // Storage array: cleared on reset, one write per cycle otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1   = regs[raddr1];
  assign rdata2   = regs[raddr2];
  assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/alu_issue_stage.sv
// Sequencing stage in front of an external combinational 4-bit ALU.
// Accepts one instruction per valid/ready handshake, reads two operands from
// a 4x4 register file, presents registered operands/control to the ALU,
// captures the ALU result and writes it back with zero/carry flag updates.
// Ports: clk, rst (sync, active-high); instr_valid/instr_ready/instr
// instruction handshake; alu_op1/alu_op2/alu_ctrl to the ALU;
// alu_result/alu_cout from the ALU; done/illegal retire pulses;
// flag_z/flag_c status flags; dbg_sel/dbg_data register debug read.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [DATA_W-1:0]  alu_op1,
  output logic [DATA_W-1:0]  alu_op2,
  output logic [2:0]         alu_ctrl,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               alu_cout,
  output logic               done,
  output logic               illegal,
  output logic               flag_z,
  output logic               flag_c,
  input  logic [REG_AW-1:0]  dbg_sel,
  output logic [DATA_W-1:0]  dbg_data
);

  state_t state, next_state;

  logic [3:0]        opcode_q;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] res_q;
  logic              cout_q;

  logic              accept;
  logic              wb_we;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic [3:0]        in_opcode;
  logic              unused_instr_bits;

  assign in_opcode         = instr[OPC_HI:OPC_LO];
  assign unused_instr_bits = ^instr[5:4];

  // LDI bypasses the ALU and writes its immediate directly.
  assign wb_data = (opcode_q == OP_LDI) ? imm_q : res_q;

  regfile_4x4 u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (wb_we),
    .waddr    (rd_q),
    .wdata    (wb_data),
    .raddr1   (instr[RS1_HI:RS1_LO]),
    .rdata1   (rdata1),
    .raddr2   (instr[RS2_HI:RS2_LO]),
    .rdata2   (rdata2),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Every instruction walks IDLE -> EXEC -> WB, so retire timing is fixed
  // regardless of opcode; illegal ops simply suppress the write.
  always_comb begin
    next_state  = state;
    instr_ready = 1'b0;
    accept      = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    wb_we       = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          accept     = 1'b1;
          next_state = EXEC;
        end
      end
      EXEC: begin
        next_state = WB;
      end
      WB: begin
        done       = 1'b1;
        illegal    = !is_legal_op(opcode_q);
        wb_we      = is_legal_op(opcode_q);
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath: operands are sampled from the register file at the accept
  // edge, so a destination equal to a source still reads the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_q <= '0;
      rd_q     <= '0;
      imm_q    <= '0;
      res_q    <= '0;
      cout_q   <= 1'b0;
      alu_op1  <= '0;
      alu_op2  <= '0;
      alu_ctrl <= '0;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
    end else begin
      if (accept) begin
        opcode_q <= in_opcode;
        rd_q     <= instr[RD_HI:RD_LO];
        imm_q    <= instr[IMM_HI:IMM_LO];
        if (is_alu_op(in_opcode)) begin
          alu_op1  <= rdata1;
          alu_op2  <= rdata2;
          alu_ctrl <= in_opcode[2:0];
        end
      end
      if (state == EXEC) begin
        res_q  <= alu_result;
        cout_q <= alu_cout;
      end
      if (wb_we) begin
        flag_z <= (wb_data == '0);
        flag_c <= is_arith_op(opcode_q) ? cout_q : 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed testbench for alu_issue_stage with a behavioural 4-bit ALU
// closing the loop between alu_op*/alu_ctrl and alu_result/alu_cout.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [3:0]  alu_op1;
  logic [3:0]  alu_op2;
  logic [2:0]  alu_ctrl;
  logic [3:0]  alu_result;
  logic        alu_cout;
  logic        done;
  logic        illegal;
  logic        flag_z;
  logic        flag_c;
  logic [1:0]  dbg_sel;
  logic [3:0]  dbg_data;

  int checkCount = 0;
  int failCount  = 0;

  alu_issue_stage dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_op1     (alu_op1),
    .alu_op2     (alu_op2),
    .alu_ctrl    (alu_ctrl),
    .alu_result  (alu_result),
    .alu_cout    (alu_cout),
    .done        (done),
    .illegal     (illegal),
    .flag_z      (flag_z),
    .flag_c      (flag_c),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference alu_4bit; SUB carry means "no borrow".
  always_comb begin
    logic [4:0] sum5;
    sum5       = 5'd0;
    alu_result = 4'd0;
    alu_cout   = 1'b0;
    case (alu_ctrl)
      3'b000: alu_result = alu_op1 & alu_op2;
      3'b001: alu_result = alu_op1 | alu_op2;
      3'b010: alu_result = ~alu_op1;
      3'b011: alu_result = alu_op1 ^ alu_op2;
      3'b100: begin
        sum5       = {1'b0, alu_op1} + {1'b0, alu_op2};
        alu_result = sum5[3:0];
        alu_cout   = sum5[4];
      end
      3'b101: begin
        sum5       = {1'b0, alu_op1} + {1'b0, ~alu_op2} + 5'd1;
        alu_result = sum5[3:0];
        alu_cout   = sum5[4];
      end
      default: alu_result = 4'd0;
    endcase
  end

  // Hard stop in case the sequence never reaches the summary.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [7:0] actual,
                             input logic [7:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=%0h required=%0h", tag, actual, expected);
    end
  endtask

  task automatic readReg(input logic [1:0] sel, output logic [3:0] value);
    dbg_sel = sel;
    #1;
    value = dbg_data;
  endtask

  task automatic checkReg(input string tag, input logic [1:0] sel,
                          input logic [3:0] expected);
    logic [3:0] value;
    readReg(sel, value);
    checkOutput(tag, {4'd0, value}, {4'd0, expected});
  endtask

  // Issues one instruction and follows it through EXEC and WB. Returns at the
  // falling edge after writeback, when the result is visible on dbg_data.
  task automatic applyStimulus(input string tag, input logic [15:0] word,
                               input logic [3:0] expOp1, input logic [3:0] expOp2,
                               input logic [2:0] expCtrl, input logic expIllegal);
    int waitCycles;
    waitCycles = 0;
    @(negedge clk);
    instr       = word;
    instr_valid = 1'b1;
    while (!instr_ready && waitCycles < 10) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput({tag, "_ready"}, {7'd0, instr_ready}, 8'd1);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    checkOutput({tag, "_exec_done"}, {7'd0, done}, 8'd0);
    checkOutput({tag, "_op1"}, {4'd0, alu_op1}, {4'd0, expOp1});
    checkOutput({tag, "_op2"}, {4'd0, alu_op2}, {4'd0, expOp2});
    checkOutput({tag, "_ctrl"}, {5'd0, alu_ctrl}, {5'd0, expCtrl});
    @(negedge clk);
    checkOutput({tag, "_done"}, {7'd0, done}, 8'd1);
    checkOutput({tag, "_illegal"}, {7'd0, illegal}, {7'd0, expIllegal});
    @(negedge clk);
    checkOutput({tag, "_done_clr"}, {7'd0, done}, 8'd0);
  endtask

  task automatic checkFlags(input string tag, input logic expZ, input logic expC);
    checkOutput({tag, "_z"}, {7'd0, flag_z}, {7'd0, expZ});
    checkOutput({tag, "_c"}, {7'd0, flag_c}, {7'd0, expC});
  endtask

  initial begin
    int doneSeen;
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    dbg_sel     = 2'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_ready", {7'd0, instr_ready}, 8'd1);
    checkOutput("rst_done", {7'd0, done}, 8'd0);
    checkOutput("rst_illegal", {7'd0, illegal}, 8'd0);
    checkFlags("rst", 1'b0, 1'b0);
    checkOutput("rst_alu", {1'b0, alu_ctrl, alu_op1}, 8'd0);
    checkOutput("rst_op2", {4'd0, alu_op2}, 8'd0);
    for (int i = 0; i < 4; i++) checkReg("rst_reg", 2'(i), 4'd0);

    $display("[TB] LDI r0,9 / LDI r1,5");
    applyStimulus("ldi_r0", 16'h8009, 4'd0, 4'd0, 3'd0, 1'b0);
    applyStimulus("ldi_r1", 16'h8405, 4'd0, 4'd0, 3'd0, 1'b0);
    checkReg("ldi_r0_val", 2'd0, 4'b1001);
    checkReg("ldi_r1_val", 2'd1, 4'b0101);
    checkFlags("ldi", 1'b0, 1'b0);

    $display("[TB] ADD r2,r0,r1");
    applyStimulus("add", 16'h4840, 4'b1001, 4'b0101, 3'b100, 1'b0);
    checkReg("add_r2", 2'd2, 4'b1110);
    checkFlags("add", 1'b0, 1'b0);

    $display("[TB] SUB r3,r0,r1 / SUB r3,r1,r0");
    applyStimulus("sub_a", 16'h5C40, 4'b1001, 4'b0101, 3'b101, 1'b0);
    checkReg("sub_a_r3", 2'd3, 4'b0100);
    checkFlags("sub_a", 1'b0, 1'b1);
    applyStimulus("sub_b", 16'h5D00, 4'b0101, 4'b1001, 3'b101, 1'b0);
    checkReg("sub_b_r3", 2'd3, 4'b1100);
    checkFlags("sub_b", 1'b0, 1'b0);

    $display("[TB] XOR r0,r0,r0 / NOT r1,r1");
    applyStimulus("xor", 16'h3000, 4'b1001, 4'b1001, 3'b011, 1'b0);
    checkReg("xor_r0", 2'd0, 4'b0000);
    checkFlags("xor", 1'b1, 1'b0);
    applyStimulus("not", 16'h2500, 4'b0101, 4'b0000, 3'b010, 1'b0);
    checkReg("not_r1", 2'd1, 4'b1010);
    checkFlags("not", 1'b0, 1'b0);

    $display("[TB] SUB r3,r2,r2 then illegal opcode");
    applyStimulus("sub_zero", 16'h5E80, 4'b1110, 4'b1110, 3'b101, 1'b0);
    checkReg("sub_zero_r3", 2'd3, 4'b0000);
    checkFlags("sub_zero", 1'b1, 1'b1);
    applyStimulus("illegal", 16'hF800, 4'b1110, 4'b1110, 3'b101, 1'b1);
    checkReg("illegal_r2", 2'd2, 4'b1110);
    checkFlags("illegal", 1'b1, 1'b1);

    $display("[TB] back-to-back with instr_valid held");
    doneSeen = 0;
    @(negedge clk);
    instr       = 16'h8803;
    instr_valid = 1'b1;
    checkOutput("b2b_ready_idle", {7'd0, instr_ready}, 8'd1);
    @(negedge clk);
    instr = 16'h8C07;
    checkOutput("b2b_ready_exec", {7'd0, instr_ready}, 8'd0);
    @(negedge clk);
    checkOutput("b2b_ready_wb", {7'd0, instr_ready}, 8'd0);
    if (done) doneSeen++;
    @(negedge clk);
    checkOutput("b2b_ready_idle2", {7'd0, instr_ready}, 8'd1);
    checkReg("b2b_r2", 2'd2, 4'd3);
    @(negedge clk);
    instr_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done) doneSeen++;
      @(negedge clk);
    end
    checkOutput("b2b_done_count", 8'(doneSeen), 8'd2);
    checkReg("b2b_r3", 2'd3, 4'd7);
    checkReg("b2b_r1", 2'd1, 4'b1010);

    $display("[TB] reset during EXEC of ADD r1,r0,r0");
    instr       = 16'h4400;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    rst         = 1'b1;
    checkOutput("abort_in_exec", {7'd0, instr_ready}, 8'd0);
    @(negedge clk);
    checkOutput("abort_done", {7'd0, done}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_done2", {7'd0, done}, 8'd0);
    checkOutput("abort_ready", {7'd0, instr_ready}, 8'd1);
    checkFlags("abort", 1'b0, 1'b0);
    checkOutput("abort_alu", {1'b0, alu_ctrl, alu_op1}, 8'd0);
    for (int i = 0; i < 4; i++) checkReg("abort_reg", 2'(i), 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
